// File: rtl/heap_responder.sv
// rtl/heap_responder.sv - noun RAM responder with bump allocator and LIFO free list
module heap_responder #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 64,
    parameter int HEAP_BASE  = 1,
    parameter int FREE_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              power,
    input  logic [1:0]        func,
    input  logic              execute,
    input  logic [ADDR_W-1:0] address1,
    input  logic [ADDR_W-1:0] address2,
    input  logic [DATA_W-1:0] write_data,
    output logic [ADDR_W-1:0] free_addr,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              is_ready,
    output logic [1:0]        error
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int PTR_W = (FREE_DEPTH > 1) ? $clog2(FREE_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_RD_A, S_RD_B, S_RD_C, S_WR, S_AL, S_FR
    } state_t;

    state_t              state_q;
    logic [1:0]          func_q;
    logic [ADDR_W-1:0]   addr1_q, addr2_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                armed_q, is_ready_q;
    logic [1:0]          error_q;
    logic [DATA_W-1:0]   rd1_q, rd2_q, ram_rdata_q;
    logic [ADDR_W-1:0]   free_addr_q, free_addr_d;
    logic [ADDR_W:0]     bump_q, bump_d;
    logic [CNT_W-1:0]    count_q, count_d, cnt_m1, cnt_d_m1;
    logic [ADDR_W-1:0]   stack_q [FREE_DEPTH];
    logic [DATA_W-1:0]   ram_q [DEPTH];

    logic                accept, have_free, bump_ok, stack_full, free_bad, push;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr, ram_raddr, top_addr;
    logic [1:0]          err_d;

    assign accept     = (state_q == S_IDLE) && is_ready_q && execute && power && armed_q;
    assign have_free  = (count_q != '0);
    assign cnt_m1     = count_q - CNT_W'(1);
    assign top_addr   = stack_q[cnt_m1[PTR_W-1:0]];
    // bump_q carries one extra bit so an exhausted heap never wraps to 0
    assign bump_ok    = !bump_q[ADDR_W];
    assign stack_full = (count_q == CNT_W'(FREE_DEPTH));
    assign free_bad   = (addr1_q < ADDR_W'(HEAP_BASE)) || ({1'b0, addr1_q} >= bump_q);
    assign ram_raddr  = (state_q == S_RD_B) ? addr2_q : addr1_q;

    always_comb begin
        count_d   = count_q;
        bump_d    = bump_q;
        err_d     = 2'b00;
        push      = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = addr1_q;
        case (state_q)
            S_WR: ram_we = 1'b1;
            S_AL: begin
                if (have_free) begin
                    ram_we    = 1'b1;
                    ram_waddr = top_addr;
                    count_d   = cnt_m1;
                end else if (bump_ok) begin
                    ram_we    = 1'b1;
                    ram_waddr = bump_q[ADDR_W-1:0];
                    bump_d    = bump_q + (ADDR_W+1)'(1);
                end else begin
                    err_d = 2'b01;
                end
            end
            S_FR: begin
                if (free_bad) begin
                    err_d = 2'b11;
                end else if (stack_full) begin
                    err_d = 2'b10;
                end else begin
                    push    = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
        ram_we   = ram_we && !rst;
        cnt_d_m1 = count_d - CNT_W'(1);
        if (push) begin
            free_addr_d = addr1_q;
        end else if (count_d != '0) begin
            free_addr_d = stack_q[cnt_d_m1[PTR_W-1:0]];
        end else begin
            free_addr_d = bump_d[ADDR_W-1:0];
        end
    end

    // RAM and free-list storage carry no reset so preloads survive rst
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_waddr] <= wdata_q;
        end
        ram_rdata_q <= ram_q[ram_raddr];
        if (push && !rst) begin
            stack_q[count_q[PTR_W-1:0]] <= addr1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            is_ready_q  <= 1'b0;
            armed_q     <= 1'b0;
            error_q     <= 2'b00;
            rd1_q       <= '0;
            rd2_q       <= '0;
            func_q      <= 2'b00;
            addr1_q     <= '0;
            addr2_q     <= '0;
            wdata_q     <= '0;
            bump_q      <= (ADDR_W+1)'(HEAP_BASE);
            count_q     <= '0;
            free_addr_q <= ADDR_W'(HEAP_BASE);
        end else begin
            if (!execute) begin
                armed_q <= 1'b1;
            end
            count_q     <= count_d;
            bump_q      <= bump_d;
            free_addr_q <= free_addr_d;
            case (state_q)
                S_INIT: begin
                    state_q    <= S_IDLE;
                    is_ready_q <= 1'b1;
                end
                S_IDLE: begin
                    if (accept) begin
                        func_q     <= func;
                        addr1_q    <= address1;
                        addr2_q    <= address2;
                        wdata_q    <= write_data;
                        error_q    <= 2'b00;
                        is_ready_q <= 1'b0;
                        armed_q    <= 1'b0;
                        case (func)
                            2'b00:   state_q <= S_RD_A;
                            2'b01:   state_q <= S_WR;
                            2'b10:   state_q <= S_AL;
                            default: state_q <= S_FR;
                        endcase
                    end
                end
                S_RD_A: state_q <= S_RD_B;
                S_RD_B: begin
                    rd1_q   <= ram_rdata_q;
                    state_q <= S_RD_C;
                end
                S_RD_C: begin
                    rd2_q      <= ram_rdata_q;
                    state_q    <= S_IDLE;
                    is_ready_q <= 1'b1;
                end
                S_AL, S_FR: begin
                    error_q    <= err_d;
                    state_q    <= S_IDLE;
                    is_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= S_IDLE;
                    is_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign free_addr  = free_addr_q;
    assign read_data1 = rd1_q;
    assign read_data2 = rd2_q;
    assign is_ready   = is_ready_q;
    assign error      = error_q;
endmodule

// File: tb/tb_heap_responder.sv
// tb/tb_heap_responder.sv - directed self-checking bench for heap_responder
module tb_heap_responder;
    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          power = 1'b1;
    logic [1:0]    func = 2'b00;
    logic          execute = 1'b0;
    logic [AW-1:0] address1 = '0;
    logic [AW-1:0] address2 = '0;
    logic [DW-1:0] write_data = '0;
    logic [AW-1:0] free_addr;
    logic [DW-1:0] read_data1, read_data2;
    logic          is_ready;
    logic [1:0]    error;

    int n_total = 0;
    int n_bad = 0;
    int busy;
    int falls;
    logic prev_rdy;

    heap_responder #(.ADDR_W(AW), .DATA_W(DW), .HEAP_BASE(1), .FREE_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .power(power), .func(func), .execute(execute),
        .address1(address1), .address2(address2), .write_data(write_data),
        .free_addr(free_addr), .read_data1(read_data1), .read_data2(read_data2),
        .is_ready(is_ready), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        execute = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_cmd(input logic [1:0] f, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                           input logic [DW-1:0] wd, output int nbusy);
        @(negedge clk);
        func = f;
        address1 = a1;
        address2 = a2;
        write_data = wd;
        execute = 1'b1;
        @(negedge clk);
        execute = 1'b0;
        nbusy = 0;
        while (is_ready !== 1'b1 && nbusy < 20) begin
            nbusy++;
            @(negedge clk);
        end
        if (nbusy >= 20) check("timeout", 32'(nbusy), 32'd0);
    endtask

    initial begin
        // reset behaviour
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(is_ready), 32'd0);
        check("rst_rd1", 32'(read_data1), 32'd0);
        check("rst_err", 32'(error), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("init_ready", 32'(is_ready), 32'd1);
        check("init_free", 32'(free_addr), 32'd1);
        check("init_err", 32'(error), 32'd0);

        // write then dual read with latency check
        run_cmd(2'b01, 4'd5, 4'd0, 16'h00AA, busy);
        check("wr_busy", 32'(busy), 32'd1);
        run_cmd(2'b01, 4'd9, 4'd0, 16'h00BB, busy);
        run_cmd(2'b00, 4'd5, 4'd9, 16'h0000, busy);
        check("rd_busy", 32'(busy), 32'd3);
        check("rd_d1", 32'(read_data1), 32'h00AA);
        check("rd_d2", 32'(read_data2), 32'h00BB);

        // execute held high across completion: exactly one write
        @(negedge clk);
        func = 2'b01; address1 = 4'd7; write_data = 16'h1234; execute = 1'b1;
        prev_rdy = is_ready;
        falls = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            write_data = 16'h5555;
            if (prev_rdy && !is_ready) falls++;
            prev_rdy = is_ready;
        end
        execute = 1'b0;
        check("hold_once", 32'(falls), 32'd1);
        run_cmd(2'b00, 4'd7, 4'd7, 16'h0000, busy);
        check("hold_d1", 32'(read_data1), 32'h1234);
        check("hold_d2", 32'(read_data2), 32'h1234);

        // power low blocks accept
        @(negedge clk);
        power = 1'b0;
        func = 2'b01; address1 = 4'd7; write_data = 16'hDEAD; execute = 1'b1;
        falls = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!is_ready) falls++;
        end
        execute = 1'b0;
        power = 1'b1;
        check("pwr_block", 32'(falls), 32'd0);
        run_cmd(2'b00, 4'd7, 4'd5, 16'h0000, busy);
        check("pwr_d1", 32'(read_data1), 32'h1234);

        // bad free above bump, then allocation sequence
        run_cmd(2'b11, 4'd1, 4'd0, 16'h0000, busy);
        check("free_above_bump", 32'(error), 32'd3);
        check("free_above_fa", 32'(free_addr), 32'd1);
        run_cmd(2'b10, 4'd0, 4'd0, 16'h0011, busy);
        check("al1_err", 32'(error), 32'd0);
        check("al1_fa", 32'(free_addr), 32'd2);
        run_cmd(2'b10, 4'd0, 4'd0, 16'h0022, busy);
        check("al2_fa", 32'(free_addr), 32'd3);
        run_cmd(2'b10, 4'd0, 4'd0, 16'h0033, busy);
        check("al3_fa", 32'(free_addr), 32'd4);
        run_cmd(2'b00, 4'd1, 4'd2, 16'h0000, busy);
        check("al_m1", 32'(read_data1), 32'h0011);
        check("al_m2", 32'(read_data2), 32'h0022);
        run_cmd(2'b00, 4'd3, 4'd3, 16'h0000, busy);
        check("al_m3", 32'(read_data1), 32'h0033);
        run_cmd(2'b11, 4'd2, 4'd0, 16'h0000, busy);
        check("fr2_err", 32'(error), 32'd0);
        check("fr2_fa", 32'(free_addr), 32'd2);
        run_cmd(2'b10, 4'd0, 4'd0, 16'h0044, busy);
        check("re_al_fa", 32'(free_addr), 32'd4);
        run_cmd(2'b00, 4'd2, 4'd1, 16'h0000, busy);
        check("re_al_m2", 32'(read_data1), 32'h0044);
        check("re_al_m1", 32'(read_data2), 32'h0011);

        // exhaust the heap
        run_cmd(2'b01, 4'd0, 4'd0, 16'h0BAD, busy);
        for (int i = 0; i < 12; i++) run_cmd(2'b10, 4'd0, 4'd0, 16'(16'h0100 + i), busy);
        check("full_fa", 32'(free_addr), 32'd0);
        check("full_err", 32'(error), 32'd0);
        run_cmd(2'b10, 4'd0, 4'd0, 16'h0099, busy);
        check("oom_err", 32'(error), 32'd1);
        check("oom_fa", 32'(free_addr), 32'd0);
        run_cmd(2'b00, 4'd0, 4'd15, 16'h0000, busy);
        check("oom_m0", 32'(read_data1), 32'h0BAD);
        check("oom_m15", 32'(read_data2), 32'h010B);

        // fill the free list, overflow and bad address
        for (int i = 1; i <= 16; i++) begin
            run_cmd(2'b11, (i == 16) ? 4'd1 : 4'(i), 4'd0, 16'h0000, busy);
            check("push_err", 32'(error), 32'd0);
        end
        check("push_fa", 32'(free_addr), 32'd1);
        run_cmd(2'b11, 4'd3, 4'd0, 16'h0000, busy);
        check("ovf_err", 32'(error), 32'd2);
        check("ovf_fa", 32'(free_addr), 32'd1);
        run_cmd(2'b11, 4'd0, 4'd0, 16'h0000, busy);
        check("bad0_err", 32'(error), 32'd3);
        run_cmd(2'b10, 4'd0, 4'd0, 16'h0077, busy);
        check("pop_err", 32'(error), 32'd0);
        check("pop_fa", 32'(free_addr), 32'd15);
        run_cmd(2'b00, 4'd1, 4'd1, 16'h0000, busy);
        check("pop_m1", 32'(read_data1), 32'h0077);

        // reset during RD_B
        run_cmd(2'b01, 4'd5, 4'd0, 16'h00AA, busy);
        run_cmd(2'b01, 4'd9, 4'd0, 16'h00BB, busy);
        @(negedge clk);
        func = 2'b00; address1 = 4'd5; address2 = 4'd9; execute = 1'b1;
        @(negedge clk);
        execute = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_ready", 32'(is_ready), 32'd0);
        check("mid_rd1", 32'(read_data1), 32'd0);
        check("mid_rd2", 32'(read_data2), 32'd0);
        check("mid_fa", 32'(free_addr), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rdy_after", 32'(is_ready), 32'd1);
        run_cmd(2'b00, 4'd5, 4'd9, 16'h0000, busy);
        check("post_d1", 32'(read_data1), 32'h00AA);
        check("post_d2", 32'(read_data2), 32'h00BB);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
